linebuf_window_ctrl: RTL and testbench
======================================

Name: linebuf_window_ctrl

Overview:
- Sequencer for a stack of KERNEL-1 BRAM line-buffer delay lines, each IMG_WIDTH deep, inside the detector/descriptor pixel pipeline.
- Accepts a raster pixel stream, tracks column and row, and gates the line-buffer clock enable.
- Marks which cycles present a complete KERNEL x KERNEL window to the downstream kernel logic.
- Detects framing errors (bad line length, early or late start-of-frame) and resynchronises to the next frame.

Parameters:
- IMG_WIDTH, 640, pixels per line; equals line-buffer depth.
- IMG_HEIGHT, 480, lines per frame.
- KERNEL, 3, window size; legal range 2..7.
- CW, clogb2(IMG_WIDTH-1), column counter width (derived localparam).
- RW, clogb2(IMG_HEIGHT-1), row counter width (derived localparam).

Ports:
- clk  in  1  single clock for the block.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  pixel present this cycle.
- in_sof  in  1  qualifies the first pixel of a frame; sampled only with in_valid.
- in_eol  in  1  qualifies the last pixel of a line; sampled only with in_valid.
- lb_ce  out  1  line-buffer shift enable, combinational.
- col  out  CW  column of the last accepted pixel, registered.
- row  out  RW  row of the last accepted pixel, registered.
- win_valid  out  1  window bottom-right equals (row,col) and the window is complete; registered.
- win_eof  out  1  one-cycle pulse on the last window of a frame; registered.
- err_sync  out  1  one-cycle framing-error pulse; registered.
- busy  out  1  high when the FSM is not in IDLE.

Behaviour:
- Reset (rst_n low, asynchronous): FSM=IDLE; col=0, row=0; win_valid, win_eof and err_sync are 0.
- Accept rule: a pixel is accepted when in_valid=1 and either:
  - state is FILL or RUN, or
  - state is IDLE and in_sof=1.
- lb_ce equals the accept condition in the same cycle, so the line buffers shift exactly once per accepted pixel.
- Pixels arriving while idle without in_sof are dropped, and lb_ce stays 0.
- Registered outputs update on the clock edge after the accept (latency 1). They hold their value when no pixel is accepted, except the pulses, which clear to 0.
- Counters:
  - col increments on each accept.
  - On an accept with col==IMG_WIDTH-1, col wraps to 0 and row increments.
  - in_sof forces col=0, row=0 for that pixel.
- FSM states:
  - IDLE -> FILL on an accepted in_sof pixel.
  - FILL (row < KERNEL-1) -> RUN when the first pixel of row KERNEL-1 is accepted.
  - RUN -> DONE on an accept with row==IMG_HEIGHT-1 and col==IMG_WIDTH-1.
  - DONE: lasts one cycle, accepts nothing, then -> IDLE.
- win_valid=1 after an accept in RUN with col>=KERNEL-1; it is never set in FILL.
- win_eof is asserted together with win_valid for pixel (IMG_HEIGHT-1, IMG_WIDTH-1).
- in_eol is a check only, not a counter source. An error is raised (err_sync=1 for one cycle) when:
  - in_eol=1 with col!=IMG_WIDTH-1, or
  - in_eol=0 with col==IMG_WIDTH-1.
  - On this error the offending pixel is still accepted (lb_ce=1), no window is flagged for it, and the FSM goes to IDLE.
- in_sof in FILL or RUN: err_sync=1; the pixel is accepted as a new (0,0) and the FSM goes to FILL. The old frame is abandoned and no win_eof is issued for it.
- An in_valid pixel in the DONE cycle is dropped. If it carries in_sof, err_sync=1 (sof too early).
- Simultaneous in_sof and in_eol on the same pixel: the sof handling takes precedence. The eol check is then applied at col 0, so it is an error unless IMG_WIDTH==1.
- busy = (state != IDLE).
- Reset mid-frame: all state clears immediately; the line-buffer contents are stale but are ignored until the next window completes FILL.

Optional Feature:
- CTRL_STATS_EN.
- When defined, two output ports are added:
  - frame_cnt[15:0]: +1 per win_eof.
  - err_cnt[15:0]: +1 per err_sync.
  - Both saturate at 16'hFFFF and reset to 0 on rst_n.
- When undefined, these ports and their registers are absent; all other behaviour is identical.

Test Plan:
- Parameters for all scenarios: IMG_WIDTH=8, IMG_HEIGHT=4, KERNEL=3.
- Clean frame, 32 pixels with correct sof/eol and in_valid continuous -> lb_ce high for 32 cycles; win_valid count=12 (rows 2-3, cols 2-7); win_eof once, one cycle after pixel (3,7); busy falls 2 cycles after the last accept.
- Bubbles: same frame with in_valid toggled 1,0,1,0 -> identical win_valid count=12; col/row hold during gaps; lb_ce=0 in the gaps.
- Short line: in_eol at col 5 of row 1 -> err_sync pulse; FSM goes IDLE; pixels without sof are dropped with lb_ce=0 until the next sof, and the next frame yields 12 windows.
- in_sof at (2,4) mid-frame -> err_sync; row=0, col=0; no win_eof for the aborted frame; the restarted frame completes normally.
- rst_n asserted low asynchronously at (3,1) -> all outputs 0 before the next clk edge; after release, a clean frame gives 12 windows.
- With CTRL_STATS_EN: 2 clean frames plus 1 short-line error -> frame_cnt=2, err_cnt=1; force err_cnt to 16'hFFFF, inject an error -> stays 16'hFFFF.

Source files
------------

// File: rtl/linebuf_window_ctrl.sv
// Raster sequencer for a KERNEL-1 deep stack of line buffers: gates lb_ce, tracks (row,col), flags complete windows and framing errors.
// Define CTRL_STATS_EN to add saturating frame_cnt / err_cnt outputs.
module linebuf_window_ctrl #(
    parameter  int IMG_WIDTH  = 640,
    parameter  int IMG_HEIGHT = 480,
    parameter  int KERNEL     = 3,
    localparam int CW         = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1,
    localparam int RW         = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic          in_sof,
    input  logic          in_eol,
    output logic          lb_ce,
    output logic [CW-1:0] col,
    output logic [RW-1:0] row,
    output logic          win_valid,
    output logic          win_eof,
    output logic          err_sync,
`ifdef CTRL_STATS_EN
    output logic [15:0]   frame_cnt,
    output logic [15:0]   err_cnt,
`endif
    output logic          busy
);

    localparam logic [CW-1:0] LAST_COL = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMG_HEIGHT - 1);
    localparam logic [CW-1:0] WIN_COL  = CW'(KERNEL - 1);
    localparam logic [RW-1:0] RUN_ROW  = RW'(KERNEL - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_col_p1;
    logic [RW-1:0] r_row_p1;
    logic          r_win_vld_p1;
    logic          r_eof_p1;
    logic          r_err_p1;

    logic          w_active;
    logic          w_accept;
    logic [CW-1:0] w_col_nxt;
    logic [RW-1:0] w_row_nxt;
    logic          w_at_last_col;
    logic          w_eol_err;
    logic          w_sof_err;
    logic          w_err;
    logic          w_win;
    logic          w_frame_end;

    // ---- stage p0: accept decision and position of the incoming pixel ----
    assign w_active = (r_state == S_FILL) || (r_state == S_RUN);
    assign w_accept = in_valid && (w_active || ((r_state == S_IDLE) && in_sof));

    always_comb begin
        w_col_nxt = r_col_p1;
        w_row_nxt = r_row_p1;
        if (in_sof) begin
            w_col_nxt = '0;
            w_row_nxt = '0;
        end else if (r_col_p1 == LAST_COL) begin
            w_col_nxt = '0;
            w_row_nxt = r_row_p1 + 1'b1;
        end else begin
            w_col_nxt = r_col_p1 + 1'b1;
        end
    end

    // in_eol only cross-checks the counted column; it never steers the counters
    assign w_at_last_col = (w_col_nxt == LAST_COL);
    assign w_eol_err     = w_accept && (in_eol != w_at_last_col);
    assign w_sof_err     = in_valid && in_sof && (w_active || (r_state == S_DONE));
    assign w_err         = w_eol_err || w_sof_err;
    assign w_frame_end   = w_accept && !in_sof && !w_eol_err && w_at_last_col
                           && (w_row_nxt == LAST_ROW);
    assign w_win         = w_accept && (r_state == S_RUN) && !in_sof && !w_eol_err
                           && (w_col_nxt >= WIN_COL);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_eol_err ? S_IDLE : S_FILL;
                end
            end
            S_FILL: begin
                if (w_accept) begin
                    if (w_eol_err) begin
                        w_state_nxt = S_IDLE;
                    end else if (in_sof) begin
                        w_state_nxt = S_FILL;
                    end else if (w_row_nxt == RUN_ROW) begin
                        w_state_nxt = S_RUN;
                    end
                end
            end
            S_RUN: begin
                if (w_accept) begin
                    if (w_eol_err) begin
                        w_state_nxt = S_IDLE;
                    end else if (in_sof) begin
                        w_state_nxt = S_FILL;
                    end else if (w_frame_end) begin
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ---- stage p1: registered position, window and error flags ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_col_p1     <= '0;
            r_row_p1     <= '0;
            r_win_vld_p1 <= 1'b0;
            r_eof_p1     <= 1'b0;
            r_err_p1     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_col_p1 <= w_col_nxt;
                r_row_p1 <= w_row_nxt;
            end
            r_win_vld_p1 <= w_win;
            r_eof_p1     <= w_win && w_frame_end;
            r_err_p1     <= w_err;
        end
    end

`ifdef CTRL_STATS_EN
    logic [15:0] r_frame_cnt;
    logic [15:0] r_err_cnt;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            if (w_win && w_frame_end) begin
                r_frame_cnt <= sat_inc16(r_frame_cnt);
            end
            if (w_err) begin
                r_err_cnt <= sat_inc16(r_err_cnt);
            end
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign err_cnt   = r_err_cnt;
`endif

    assign lb_ce     = w_accept;
    assign col       = r_col_p1;
    assign row       = r_row_p1;
    assign win_valid = r_win_vld_p1;
    assign win_eof   = r_eof_p1;
    assign err_sync  = r_err_p1;
    assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_linebuf_window_ctrl.sv
// Bench for linebuf_window_ctrl (8x4 image, 3x3 kernel): frame-index reference model checked every cycle plus directed scenarios.
module tb_linebuf_window_ctrl;
    localparam int W = 8;
    localparam int H = 4;
    localparam int K = 3;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_sof   = 1'b0;
    logic       in_eol   = 1'b0;
    logic       lb_ce, win_valid, win_eof, err_sync, busy;
    logic [2:0] col;
    logic [1:0] row;
`ifdef CTRL_STATS_EN
    logic [15:0] frame_cnt, err_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int n_win = 0, n_eof = 0, n_err = 0, n_ce = 0;

    // reference model: frame position kept as a linear pixel index
    bit m_frame = 0, m_cool = 0;
    int m_idx = 0, m_col = 0, m_row = 0;
    bit m_win = 0, m_eof = 0, m_err = 0;

    linebuf_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .KERNEL(K)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_eol    (in_eol),
        .lb_ce     (lb_ce),
        .col       (col),
        .row       (row),
        .win_valid (win_valid),
        .win_eof   (win_eof),
        .err_sync  (err_sync),
`ifdef CTRL_STATS_EN
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // per-cycle comparison against the model, then advance the model
    initial begin
        bit acc, bad;
        int idx, c, r;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_frame = 0; m_cool = 0; m_idx = 0; m_col = 0; m_row = 0;
                m_win = 0; m_eof = 0; m_err = 0;
            end
            acc = in_valid && !m_cool && (m_frame || in_sof);
            chk("lb_ce", lb_ce, acc);
            chk("busy", busy, m_frame || m_cool);
            chk("col", col, m_col);
            chk("row", row, m_row);
            chk("win_valid", win_valid, m_win);
            chk("win_eof", win_eof, m_eof);
            chk("err_sync", err_sync, m_err);
            if (win_valid === 1'b1) n_win++;
            if (win_eof === 1'b1) n_eof++;
            if (err_sync === 1'b1) n_err++;
            if (lb_ce === 1'b1) n_ce++;
            m_win = 0; m_eof = 0; m_err = 0;
            if (rst_n) begin
                if (m_cool) begin
                    m_cool = 0;
                    if (in_valid && in_sof) m_err = 1;
                end else if (acc) begin
                    idx = in_sof ? 0 : m_idx + 1;
                    c = idx % W;
                    r = idx / W;
                    bad = (in_eol != (c == W - 1));
                    if (in_sof && m_frame) m_err = 1;
                    m_idx = idx; m_col = c; m_row = r;
                    if (bad) begin
                        m_err = 1;
                        m_frame = 0;
                    end else begin
                        m_frame = 1;
                        m_win = !in_sof && (r >= K - 1) && (c >= K - 1);
                        if (idx == W * H - 1) begin
                            m_eof = m_win;
                            m_frame = 0;
                            m_cool = 1;
                        end
                    end
                end
            end
        end
    end

    task automatic pix(input bit v, input bit s, input bit e);
        @(posedge clk);
        #1;
        in_valid = v; in_sof = s; in_eol = e;
    endtask

    task automatic px(input int idx);
        pix(1'b1, idx == 0, (idx % W) == W - 1);
    endtask

    task automatic frame(input bit bub);
        for (int i = 0; i < W * H; i++) begin
            px(i);
            if (bub) pix(1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) pix(1'b0, 1'b0, 1'b0);
    endtask

    task automatic clr();
        n_win = 0; n_eof = 0; n_err = 0; n_ce = 0;
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1;
        chk("rst_col", col, 0);
        chk("rst_row", row, 0);
        chk("rst_win", win_valid, 0);
        chk("rst_eof", win_eof, 0);
        chk("rst_err", err_sync, 0);
        chk("rst_busy", busy, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // clean frame, continuous valid
        clr();
        frame(1'b0);
        pix(1'b0, 1'b0, 1'b0);
        chk("s1_eof_pulse", win_eof, 1);
        chk("s1_busy_done", busy, 1);
        chk("s1_row_last", row, 3);
        chk("s1_col_last", col, 7);
        pix(1'b0, 1'b0, 1'b0);
        chk("s1_busy_fall", busy, 0);
        chk("s1_eof_clear", win_eof, 0);
        idle(2);
        chk("s1_windows", n_win, 12);
        chk("s1_eofs", n_eof, 1);
        chk("s1_ce", n_ce, 32);

        // same frame with a bubble after every pixel
        clr();
        frame(1'b1);
        idle(3);
        chk("s2_windows", n_win, 12);
        chk("s2_eofs", n_eof, 1);
        chk("s2_ce", n_ce, 32);

        // short line: eol at col 5 of row 1
        clr();
        for (int i = 0; i < W; i++) px(i);
        for (int c = 0; c < 6; c++) pix(1'b1, 1'b0, c == 5);
        pix(1'b0, 1'b0, 1'b0);
        chk("s3_err_pulse", err_sync, 1);
        chk("s3_idle", busy, 0);
        chk("s3_row", row, 1);
        chk("s3_col", col, 5);
        for (int i = 0; i < 4; i++) pix(1'b1, 1'b0, 1'b0);
        pix(1'b0, 1'b0, 1'b0);
        chk("s3_dropped_ce", n_ce, 14);
        frame(1'b0);
        idle(3);
        chk("s3_windows", n_win, 12);
        chk("s3_eofs", n_eof, 1);
        chk("s3_errs", n_err, 1);

        // sof arriving at (2,4) restarts the frame
        clr();
        for (int i = 0; i < 20; i++) px(i);
        px(0);
        px(1);
        chk("s4_err_pulse", err_sync, 1);
        chk("s4_row", row, 0);
        chk("s4_col", col, 0);
        chk("s4_busy", busy, 1);
        for (int i = 2; i < W * H; i++) px(i);
        idle(3);
        chk("s4_windows", n_win, 14);
        chk("s4_eofs", n_eof, 1);
        chk("s4_errs", n_err, 1);

        // asynchronous reset after pixel (3,1)
        clr();
        for (int i = 0; i < 26; i++) px(i);
        pix(1'b0, 1'b0, 1'b0);
        chk("s5_row_pre", row, 3);
        chk("s5_col_pre", col, 1);
        chk("s5_busy_pre", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("s5_col", col, 0);
        chk("s5_row", row, 0);
        chk("s5_busy", busy, 0);
        chk("s5_win", win_valid, 0);
        chk("s5_eof", win_eof, 0);
        chk("s5_err", err_sync, 0);
        chk("s5_ce", lb_ce, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        clr();
        frame(1'b0);
        idle(3);
        chk("s5_windows", n_win, 12);
        chk("s5_eofs", n_eof, 1);

        // sof during the DONE cycle is dropped and flagged
        clr();
        frame(1'b0);
        px(0);
        pix(1'b0, 1'b0, 1'b0);
        chk("s6_err_pulse", err_sync, 1);
        chk("s6_busy", busy, 0);
        idle(2);
        chk("s6_errs", n_err, 1);
        chk("s6_ce", n_ce, 32);

`ifdef CTRL_STATS_EN
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("st_frame_rst", frame_cnt, 0);
        chk("st_err_rst", err_cnt, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        frame(1'b0);
        idle(2);
        frame(1'b0);
        idle(2);
        for (int i = 0; i < W; i++) px(i);
        for (int c = 0; c < 6; c++) pix(1'b1, 1'b0, c == 5);
        idle(2);
        chk("st_frame_cnt", frame_cnt, 2);
        chk("st_err_cnt", err_cnt, 1);
        force dut.r_err_cnt = 16'hFFFF;
        @(posedge clk);
        #1 release dut.r_err_cnt;
        clr();
        pix(1'b1, 1'b1, 1'b0);
        pix(1'b1, 1'b0, 1'b1);
        idle(2);
        chk("st_err_seen", n_err, 1);
        chk("st_err_sat", err_cnt, 16'hFFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
